pulse_tx: RTL and testbench
===========================

PULSE_TX -- requirements
Module: pulse_tx

Interface
REQ-001 Parameter: CW, 8, width of the pulse-count input.
REQ-002 Parameter: HIGH_CYCLES, 2, clock cycles X is held high per pulse; legal range 1..255.
REQ-003 Parameter: LOW_CYCLES, 2, clock cycles X is held low after each pulse; legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  request to transmit a pulse train.
REQ-007 Port: count  input  CW  number of pulses to emit; sampled only when a start is accepted.
REQ-008 Port: ready  output  1  high when a start will be accepted this cycle.
REQ-009 Port: X  output  1  serial pulse line; registered output, no combinational path from any input.
REQ-010 Port: busy  output  1  high while a train is in progress.
REQ-011 Port: done  output  1  single-cycle completion strobe.

Function
REQ-012 FSM states: IDLE, HIGH, LOW, DONE; any unencoded state returns to IDLE on the next edge.
REQ-013 IDLE: ready=1, busy=0, X=0, done=0.
REQ-014 Start accepted when start=1 and ready=1 at a rising edge; count is latched into the remaining-pulse register at that edge.
REQ-015 Accepted start with count!=0 moves to HIGH; X=1 from the following cycle.
REQ-016 Accepted start with count=0 moves directly to DONE; no pulse is emitted.
REQ-017 HIGH: X=1 for exactly HIGH_CYCLES cycles, then move to LOW and decrement the remaining-pulse count by 1.
REQ-018 LOW: X=0 for exactly LOW_CYCLES cycles; then move to HIGH if remaining>0, else to DONE.
REQ-019 DONE: done=1 and ready=0 for exactly one cycle, then move to IDLE.
REQ-020 busy=1 in HIGH and LOW, 0 otherwise; ready=1 only in IDLE.
REQ-021 start while not ready is ignored and not queued; count changes outside acceptance have no effect.
REQ-022 A train of N>0 produces exactly N rising edges on X, has busy high for N*(HIGH_CYCLES+LOW_CYCLES) cycles, and asserts done on the cycle after the final LOW phase.
REQ-023 start asserted in the cycle DONE returns to IDLE is accepted in that IDLE cycle; the minimum inter-train gap is DONE plus one IDLE cycle.
REQ-024 Phase counter is 8 bits; it reloads on every state entry and never wraps within a phase.
REQ-025 count = 2^CW-1 completes without overflow of the remaining-pulse register.

Reset
REQ-026 reset=0 forces IDLE asynchronously, X=0, busy=0, done=0, ready=1 once the state settles, and clears all counters, including mid-train.
REQ-027 After reset is released, the first rising edge with start=1 is accepted normally.

Configuration
REQ-028 Macro PULSE_TX_ABORT_EN defined: adds port abort (input, 1); abort=1 at an edge in HIGH or LOW moves to IDLE, drives X=0 from the next cycle, and produces no done strobe.
REQ-029 Macro PULSE_TX_ABORT_EN undefined: no abort port; every accepted train runs to completion.

Verification
REQ-030 Defaults; start=1, count=3 at cycle 0 -> X high cycles 1-2, 5-6, 9-10; done=1 at cycle 13; ready=1 at cycle 14.
REQ-031 start=1, count=0 -> X stays 0, done=1 in the next cycle, busy never asserted.
REQ-032 start held high continuously with count=1 -> back-to-back trains; X rising edges 6 cycles apart (4 busy + DONE + IDLE).
REQ-033 reset driven low in the second HIGH cycle of pulse 2 of 4 -> X=0 immediately, no done; a new start with count=1 after release -> one clean pulse.
REQ-034 PULSE_TX_ABORT_EN defined; abort during LOW of pulse 1 of 5 -> only 1 rising edge, done stays 0, ready=1 the next cycle.
REQ-035 Every scenario: X feeds a rising-edge detector; its pulse count equals the accepted count.

Source files
------------

// File: rtl/pulse_tx.sv
// pulse_tx: emits a train of `count` pulses on X, each HIGH_CYCLES high
// followed by LOW_CYCLES low, then a one-cycle done strobe.
// Optional feature: define PULSE_TX_ABORT_EN to add an abort input that
// cancels a train in progress without a done strobe.
module pulse_tx #(
    parameter int unsigned CW          = 8,
    parameter int unsigned HIGH_CYCLES = 2,
    parameter int unsigned LOW_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] count,
`ifdef PULSE_TX_ABORT_EN
    input  logic          abort,
`endif
    output logic          ready,
    output logic          X,
    output logic          busy,
    output logic          done
);

    localparam int unsigned PW = 8;
    localparam logic [PW-1:0] HIGH_LOAD = PW'(HIGH_CYCLES - 1);
    localparam logic [PW-1:0] LOW_LOAD  = PW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] REM_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_nxt;
    logic [PW-1:0] phase_q, phase_nxt;
    logic [CW-1:0] rem_q,   rem_nxt;
    logic          x_nxt, busy_nxt, done_nxt, ready_nxt;
    logic          abort_c;

`ifdef PULSE_TX_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            rem_q   <= '0;
            X       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state_q <= state_nxt;
            phase_q <= phase_nxt;
            rem_q   <= rem_nxt;
            X       <= x_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            ready   <= ready_nxt;
        end
    end

    // Next state, phase/remaining counters, and output decode of the next state
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        rem_nxt   = rem_q;
        x_nxt     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_nxt = count;
                    if (count != '0) begin
                        state_nxt = HIGH;
                        phase_nxt = HIGH_LOAD;
                    end else begin
                        state_nxt = DONE;
                        phase_nxt = '0;
                    end
                end
            end
            HIGH: begin
                if (abort_c) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    rem_nxt   = '0;
                end else if (phase_q == '0) begin
                    state_nxt = LOW;
                    phase_nxt = LOW_LOAD;
                    rem_nxt   = rem_q - REM_ONE;
                end else begin
                    phase_nxt = phase_q - PW'(1);
                end
            end
            LOW: begin
                if (abort_c) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    rem_nxt   = '0;
                end else if (phase_q == '0) begin
                    if (rem_q != '0) begin
                        state_nxt = HIGH;
                        phase_nxt = HIGH_LOAD;
                    end else begin
                        state_nxt = DONE;
                        phase_nxt = '0;
                    end
                end else begin
                    phase_nxt = phase_q - PW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                rem_nxt   = '0;
            end
        endcase

        // Outputs are registered copies of the decode of the state being entered
        x_nxt     = (state_nxt == HIGH);
        busy_nxt  = (state_nxt == HIGH) || (state_nxt == LOW);
        done_nxt  = (state_nxt == DONE);
        ready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_pulse_tx.sv
// tb_pulse_tx: directed table-driven bench for pulse_tx with default parameters.
module tb_pulse_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] count;
    logic       abort;
    logic       ready, X, busy, done;

    int n_vec;
    int n_err;
    int rises;
    logic x_prev;

    typedef struct {
        logic       start;
        logic [7:0] cnt;
        logic       abort;
        logic       x;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs[$];

    pulse_tx #(.CW(8), .HIGH_CYCLES(2), .LOW_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .count (count),
`ifdef PULSE_TX_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .X     (X),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge detector on X, sampled away from the active edge
    initial begin
        rises  = 0;
        x_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (X === 1'b1 && x_prev !== 1'b1) rises = rises + 1;
            x_prev = X;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [7:0] c, input logic a,
                       input logic x, input logic b, input logic d, input logic r);
        vec_t v;
        v.start = s; v.cnt = c; v.abort = a;
        v.x = x; v.busy = b; v.done = d; v.ready = r;
        vecs.push_back(v);
    endtask

    // Apply each record in its own cycle: drive inputs and check outputs at the negedge
    task automatic run(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            count = vecs[i].cnt;
            abort = vecs[i].abort;
            chk($sformatf("%s c%0d X", tag, i),     int'(X),     int'(vecs[i].x));
            chk($sformatf("%s c%0d busy", tag, i),  int'(busy),  int'(vecs[i].busy));
            chk($sformatf("%s c%0d done", tag, i),  int'(done),  int'(vecs[i].done));
            chk($sformatf("%s c%0d ready", tag, i), int'(ready), int'(vecs[i].ready));
        end
        vecs.delete();
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    int r0;
    int busy_cycles;
    int done_at;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        start = 1'b0;
        count = 8'd0;
        abort = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset X", int'(X), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset ready", int'(ready), 1);
        reset = 1'b1;

        // count=3: X high 1-2, 5-6, 9-10; done at 13; ready at 14. Late start and count noise ignored.
        r0 = rises;
        add(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 12; c++)
            add(c == 5, 8'(c * 17), 1'b0, ((c - 1) % 4) < 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run("cnt3");
        chk("cnt3 rises", rises - r0, 3);

        // count=0: straight to DONE, no pulse, busy never set; start during DONE ignored
        r0 = rises;
        add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run("cnt0");
        chk("cnt0 rises", rises - r0, 0);

        // start held with count=1: trains back to back, rising edges at cycles 1 and 7
        r0 = rises;
        for (int t = 0; t < 2; t++) begin
            add(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            add(1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            add(1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            add(1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            add(1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            add(t == 0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run("b2b");
        chk("b2b rises", rises - r0, 2);

        // Reset in second HIGH cycle of pulse 2 of 4, then a clean single pulse
        r0 = rises;
        add(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 5; c++)
            add(1'b0, 8'd4, 1'b0, ((c - 1) % 4) < 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            count = vecs[i].cnt;
            chk($sformatf("rst4 c%0d X", i), int'(X), int'(vecs[i].x));
        end
        vecs.delete();
        @(negedge clk);
        start = 1'b0;
        chk("rst4 pre X", int'(X), 1);
        #1 reset = 1'b0;
        #1;
        chk("rst4 async X", int'(X), 0);
        chk("rst4 async busy", int'(busy), 0);
        chk("rst4 async ready", int'(ready), 1);
        repeat (2) begin
            @(negedge clk);
            chk("rst4 hold done", int'(done), 0);
        end
        chk("rst4 rises", rises - r0, 2);
        reset = 1'b1;
        r0 = rises;
        add(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run("post");
        chk("post rises", rises - r0, 1);

`ifdef PULSE_TX_ABORT_EN
        // Abort during LOW of pulse 1 of 5: back to IDLE, no done
        r0 = rises;
        add(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run("abort");
        chk("abort rises", rises - r0, 1);
`endif

        // count=255: 255 pulses, busy for 1020 cycles, done at cycle 1021
        r0 = rises;
        busy_cycles = 0;
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        count = 8'd255;
        for (int c = 1; c <= 1200 && done_at < 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            count = 8'd0;
            if (busy === 1'b1) busy_cycles = busy_cycles + 1;
            if (done === 1'b1) done_at = c;
        end
        chk("max done cycle", done_at, 1021);
        chk("max busy cycles", busy_cycles, 1020);
        chk("max rises", rises - r0, 255);
        @(negedge clk);
        chk("max ready after", int'(ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
